note_rom_arbiter: RTL and testbench

- Shares one synchronous note ROM between NUM_REQ independent voice sequencers for polyphonic playback.
- Each sequencer posts an address request; the arbiter grants in round-robin order and issues one ROM read per grant.
- It waits the ROM read latency, then returns the word with a per-requester valid pulse.
- Sits between the voice control units and the single ROM instance.

---
 rtl/note_rom_arbiter_pkg.sv | 32 +++
 rtl/note_rom_arbiter_rr_picker.sv | 34 +++
 rtl/note_rom_arbiter.sv | 144 ++++++++++++++
 tb/tb_note_rom_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_rom_arbiter_pkg.sv
// Purpose: shared types and sizing helpers for the note ROM arbiter family.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: FSM state encodings, ROM address-width helper, wait-counter width helper.
package note_rom_arbiter_pkg;

    // State encodings kept as named constants so other shared-resource
    // arbiters can reuse the same values in waveforms and assertions.
    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_ISSUE_ENC = 2'd1;
    localparam logic [1:0] ST_WAIT_ENC  = 2'd2;
    localparam logic [1:0] ST_RESP_ENC  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE_ENC,
        ISSUE = ST_ISSUE_ENC,
        WAIT  = ST_WAIT_ENC,
        RESP  = ST_RESP_ENC
    } state_e;

    // Address width for a ROM of the given depth (never below one bit).
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of a counter that must hold values 0..lat.
    function automatic int wait_cnt_width(input int lat);
        return (lat > 0) ? $clog2(lat + 1) : 1;
    endfunction

endpackage

// File: rtl/note_rom_arbiter_rr_picker.sv
// Purpose: round-robin winner selection, first set request bit after rr_ptr (wrapping).
// Latency: purely combinational, zero cycles.
// Backpressure: none; found=0 when no request is pending.
//
// Ports: req (request vector), rr_ptr (last served index),
//        winner (selected index), found (any request present).
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic [IW-1:0]      winner,
    output logic               found
);

    int idx;

    // Scan from the farthest position back to the nearest so the last hit
    // written is the one closest after rr_ptr, i.e. the highest priority.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req[IW'(idx)]) begin
                winner = IW'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/note_rom_arbiter.sv
// Purpose: round-robin sharing of one synchronous note ROM among NUM_REQ voice sequencers.
// Latency: req seen in IDLE cycle c0 -> gnt/rom_en in c1 -> rsp_valid/rsp_data in c0+2+ROM_LATENCY.
// Backpressure: one access per ROM_LATENCY+3 cycles; requesters hold req until their rsp_valid.
//
// Ports: clk/rst (async active-high); req/req_addr from sequencers; gnt, rsp_valid,
//        rsp_data back to sequencers; rom_en/rom_addr/rom_data to the ROM; busy status.
module note_rom_arbiter
    import note_rom_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ROM_WIDTH   = 16,
    parameter int ROM_SIZE    = 256,
    parameter int ROM_LATENCY = 1,
    localparam int AW         = addr_width(ROM_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [ROM_WIDTH-1:0]  rsp_data,
    output logic                  rom_en,
    output logic [AW-1:0]         rom_addr,
    input  logic [ROM_WIDTH-1:0]  rom_data,
    output logic                  busy
);

    localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WCW = wait_cnt_width(ROM_LATENCY);

    // A zero-latency ROM cannot be captured by the WAIT state, so refuse it.
    if (ROM_LATENCY < 1) begin : g_bad_latency
        $error("note_rom_arbiter: ROM_LATENCY must be >= 1");
    end

    state_e               state_q,     state_d;
    logic [NUM_REQ-1:0]   gnt_q,       gnt_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [ROM_WIDTH-1:0] rsp_data_q,  rsp_data_d;
    logic                 rom_en_q,    rom_en_d;
    logic [AW-1:0]        rom_addr_q,  rom_addr_d;
    logic                 busy_q,      busy_d;
    logic [IW-1:0]        owner_q,     owner_d;
    logic [IW-1:0]        rr_ptr_q,    rr_ptr_d;
    logic [WCW-1:0]       wait_cnt_q,  wait_cnt_d;

    logic [IW-1:0]        winner;
    logic                 found;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .winner (winner),
        .found  (found)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rom_en_d    = 1'b0;
        rsp_data_d  = rsp_data_q;
        rom_addr_d  = rom_addr_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    // Address is sampled only here; later req_addr changes
                    // cannot disturb the read in flight.
                    owner_d        = winner;
                    rom_addr_d     = req_addr[int'(winner)*AW +: AW];
                    gnt_d[winner]  = 1'b1;
                    rom_en_d       = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                wait_cnt_d = WCW'(ROM_LATENCY - 1);
                state_d    = WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == '0) begin
                    // rom_data is valid in this cycle, ROM_LATENCY cycles after rom_en.
                    rsp_data_d           = rom_data;
                    rsp_valid_d[owner_q] = 1'b1;
                    rr_ptr_d             = owner_q;
                    state_d              = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - WCW'(1);
                end
            end
            RESP: begin
                // No arbitration here: the next grant waits for IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            busy_q      <= 1'b0;
            owner_q     <= '0;
            rr_ptr_q    <= IW'(NUM_REQ - 1);
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rom_en_q    <= rom_en_d;
            rom_addr_q  <= rom_addr_d;
            busy_q      <= busy_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rom_en    = rom_en_q;
    assign rom_addr  = rom_addr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_note_rom_arbiter.sv
// Purpose: self-checking bench for note_rom_arbiter with ROM_LATENCY=1 (dut_a) and 3 (dut_b).
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_note_rom_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // dut_a: ROM_LATENCY=1, dut_b: ROM_LATENCY=3
    logic [N-1:0]    a_req = '0,  b_req = '0;
    logic [N*AW-1:0] a_addr = '0, b_addr = '0;
    logic [N-1:0]    a_gnt, b_gnt, a_rsp_valid, b_rsp_valid;
    logic [W-1:0]    a_rsp_data, b_rsp_data, a_rom_data, b_rom_data;
    logic            a_rom_en, b_rom_en, a_busy, b_busy;
    logic [AW-1:0]   a_rom_addr, b_rom_addr;

    note_rom_arbiter #(.NUM_REQ(N), .ROM_WIDTH(W), .ROM_SIZE(256), .ROM_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst), .req(a_req), .req_addr(a_addr), .gnt(a_gnt),
        .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rom_en(a_rom_en),
        .rom_addr(a_rom_addr), .rom_data(a_rom_data), .busy(a_busy));

    note_rom_arbiter #(.NUM_REQ(N), .ROM_WIDTH(W), .ROM_SIZE(256), .ROM_LATENCY(3)) dut_b (
        .clk(clk), .rst(rst), .req(b_req), .req_addr(b_addr), .gnt(b_gnt),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rom_en(b_rom_en),
        .rom_addr(b_rom_addr), .rom_data(b_rom_data), .busy(b_busy));

    // ROM contents: high byte = addr + 0x28, low byte = addr (0x12 -> 0x3A12).
    function automatic logic [W-1:0] romf(input logic [AW-1:0] a);
        logic [7:0] hi;
        hi = a + 8'h28;
        return {hi, a};
    endfunction

    // Synchronous ROM models: a slot holds {en, addr}; data not belonging to
    // an enabled read shows as 0xDEAD so mistimed captures stand out.
    logic [AW:0] a_pipe;
    logic [AW:0] b_pipe [3];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a_pipe <= '0;
            for (int k = 0; k < 3; k++) b_pipe[k] <= '0;
        end else begin
            a_pipe    <= {a_rom_en, a_rom_addr};
            b_pipe[0] <= {b_rom_en, b_rom_addr};
            b_pipe[1] <= b_pipe[0];
            b_pipe[2] <= b_pipe[1];
        end
    end

    assign a_rom_data = a_pipe[AW]    ? romf(a_pipe[AW-1:0])    : 16'hDEAD;
    assign b_rom_data = b_pipe[2][AW] ? romf(b_pipe[2][AW-1:0]) : 16'hDEAD;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: each access is a grant at edge g, response at
    // edge g+1+LAT, back to arbitrating from edge g+3+LAT.
    int             m_lat  [2] = '{1, 3};
    int             m_edge [2];
    bit             m_txn  [2];
    int             m_g    [2];
    int             m_own  [2];
    int             m_ptr  [2];
    logic [AW-1:0]  m_addr [2];
    logic [W-1:0]   m_data [2];
    logic [N-1:0]   x_gnt  [2];
    logic [N-1:0]   x_rsp  [2];
    logic [N-1:0]   mr;
    logic [N*AW-1:0] mra;
    int             mw, me;

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_edge[d] = 0; m_txn[d] = 1'b0; m_g[d] = 0; m_own[d] = 0;
                m_ptr[d] = N - 1; m_addr[d] = '0; m_data[d] = '0;
                x_gnt[d] = '0; x_rsp[d] = '0;
            end else begin
                mr  = (d == 0) ? a_req  : b_req;
                mra = (d == 0) ? a_addr : b_addr;
                me  = m_edge[d];
                if (m_txn[d] && me == m_g[d] + 1 + m_lat[d]) begin
                    m_ptr[d]  = m_own[d];
                    m_data[d] = romf(m_addr[d]);
                end
                if (m_txn[d] && me == m_g[d] + 2 + m_lat[d]) begin
                    m_txn[d] = 1'b0;
                end else if (!m_txn[d] && mr != '0) begin
                    mw = -1;
                    for (int k = 1; k <= N; k++)
                        if (mw < 0 && mr[(m_ptr[d] + k) % N]) mw = (m_ptr[d] + k) % N;
                    m_txn[d]  = 1'b1;
                    m_g[d]    = me;
                    m_own[d]  = mw;
                    m_addr[d] = mra[mw*AW +: AW];
                end
                x_gnt[d] = (m_txn[d] && me == m_g[d]) ? (N'(1) << m_own[d]) : '0;
                x_rsp[d] = (m_txn[d] && me == m_g[d] + 1 + m_lat[d]) ? (N'(1) << m_own[d]) : '0;
                m_edge[d] = me + 1;
            end
        end
    end

    task automatic cmp(input int d, input logic [N-1:0] g, input logic [N-1:0] rv,
                       input logic en, input logic [AW-1:0] ra, input logic [W-1:0] rd,
                       input logic bz);
        chk($sformatf("m%0d_gnt", d),       32'(g),  32'(x_gnt[d]));
        chk($sformatf("m%0d_rsp_valid", d), 32'(rv), 32'(x_rsp[d]));
        chk($sformatf("m%0d_rom_en", d),    32'(en), 32'(x_gnt[d] != '0));
        chk($sformatf("m%0d_rom_addr", d),  32'(ra), 32'(m_addr[d]));
        chk($sformatf("m%0d_rsp_data", d),  32'(rd), 32'(m_data[d]));
        chk($sformatf("m%0d_busy", d),      32'(bz), 32'(m_txn[d]));
    endtask

    always @(posedge clk) begin
        #2;
        cmp(0, a_gnt, a_rsp_valid, a_rom_en, a_rom_addr, a_rsp_data, a_busy);
        cmp(1, b_gnt, b_rsp_valid, b_rom_en, b_rom_addr, b_rsp_data, b_busy);
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        int r;
        r = -1;
        if ($countones(v) == 1)
            for (int k = 0; k < N; k++) if (v[k]) r = k;
        return r;
    endfunction

    int gseq [16];
    int gcyc [16];
    int ng, c1, c2, v1, v2, en_c, rv_c;
    logic [N-1:0] rv_v;
    logic [W-1:0] rd_v;

    initial begin
        // Reset state
        step(); step();
        rst = 1'b0;
        chk("reset_gnt", 32'(a_gnt), 32'h0);
        chk("reset_busy", 32'(a_busy), 32'h0);
        chk("reset_rom_addr", 32'(a_rom_addr), 32'h0);
        chk("reset_rsp_data", 32'(a_rsp_data), 32'h0);

        // Single request: addr 0x12 -> 0x3A12 in c3
        a_addr = {8'h00, 8'h00, 8'h00, 8'h12};
        a_req  = 4'b0001;
        step();
        chk("single_gnt_c1", 32'(a_gnt), 32'b0001);
        chk("single_rom_addr_c1", 32'(a_rom_addr), 32'h12);
        step();
        step();
        chk("single_rsp_valid_c3", 32'(a_rsp_valid), 32'b0001);
        chk("single_rsp_data_c3", 32'(a_rsp_data), 32'h3A12);
        a_req = '0;
        step(); step();

        // Simultaneous 0110 from reset: gnt 1 at c1, gnt 2 at c5
        rst = 1'b1; step(); rst = 1'b0;
        a_addr = {8'h00, 8'h42, 8'h21, 8'h00};
        a_req  = 4'b0110;
        c1 = -1; c2 = -1; v1 = -1; v2 = -1;
        for (int t = 1; t <= 12; t++) begin
            step();
            if (a_gnt != '0) begin
                if (c1 < 0) begin c1 = t; v1 = oh2i(a_gnt); end
                else if (c2 < 0) begin c2 = t; v2 = oh2i(a_gnt); end
            end
            if (a_rsp_valid[1]) a_req[1] = 1'b0;
            if (a_rsp_valid[2]) a_req[2] = 1'b0;
        end
        chk("simul_first_cycle", 32'(c1), 32'd1);
        chk("simul_first_idx", 32'(v1), 32'd1);
        chk("simul_second_cycle", 32'(c2), 32'd5);
        chk("simul_second_idx", 32'(v2), 32'd2);

        // Full load: 16 accesses, order 0,1,2,3 repeated, 4 cycles apart
        rst = 1'b1; step(); rst = 1'b0;
        a_addr = {8'h33, 8'h32, 8'h31, 8'h30};
        a_req  = 4'b1111;
        ng = 0;
        for (int t = 1; t <= 80; t++) begin
            if (ng < 16) begin
                step();
                if (a_gnt != '0) begin
                    gseq[ng] = oh2i(a_gnt);
                    gcyc[ng] = t;
                    ng++;
                end
            end
        end
        a_req = '0;
        chk("full_grant_count", 32'(ng), 32'd16);
        for (int k = 0; k < ng; k++) begin
            chk($sformatf("full_order_%0d", k), 32'(gseq[k]), 32'(k % 4));
            if (k > 0) chk($sformatf("full_spacing_%0d", k), 32'(gcyc[k] - gcyc[k-1]), 32'd4);
        end
        repeat (6) step();
        chk("full_idle_after", 32'(a_busy), 32'h0);

        // ROM_LATENCY=3: req 1000 addr 0xFF
        b_addr = {8'hFF, 24'h0};
        b_req  = 4'b1000;
        en_c = -1; rv_c = -1; rv_v = '0; rd_v = '0;
        for (int t = 1; t <= 8; t++) begin
            step();
            if (b_rom_en && en_c < 0) en_c = t;
            if (b_rsp_valid != '0 && rv_c < 0) begin
                rv_c = t; rv_v = b_rsp_valid; rd_v = b_rsp_data; b_req = '0;
            end
            if (t <= 4) chk($sformatf("lat3_rom_addr_c%0d", t), 32'(b_rom_addr), 32'hFF);
        end
        chk("lat3_rom_en_cycle", 32'(en_c), 32'd1);
        chk("lat3_rsp_cycle", 32'(rv_c), 32'd5);
        chk("lat3_rsp_valid", 32'(rv_v), 32'b1000);
        chk("lat3_rsp_data", 32'(rd_v), 32'h27FF);

        // req0 dropped during WAIT: response still pulses, then idle
        a_addr = {24'h0, 8'h05};
        a_req  = 4'b0001;
        step();
        step();
        a_req = '0;
        step();
        chk("drop_rsp_valid", 32'(a_rsp_valid), 32'b0001);
        chk("drop_rsp_data", 32'(a_rsp_data), 32'h2D05);
        step();
        chk("drop_busy_idle", 32'(a_busy), 32'h0);
        step();
        chk("drop_no_gnt", 32'(a_gnt), 32'h0);

        // Reset during WAIT
        a_addr = {24'h0, 8'h07};
        a_req  = 4'b0001;
        step();
        step();
        rst = 1'b1;
        a_req = '0;
        #1;
        chk("rst_mid_gnt", 32'(a_gnt), 32'h0);
        chk("rst_mid_rsp_valid", 32'(a_rsp_valid), 32'h0);
        chk("rst_mid_rom_en", 32'(a_rom_en), 32'h0);
        chk("rst_mid_rom_addr", 32'(a_rom_addr), 32'h0);
        chk("rst_mid_rsp_data", 32'(a_rsp_data), 32'h0);
        chk("rst_mid_busy", 32'(a_busy), 32'h0);
        step();
        rst = 1'b0;
        for (int t = 0; t < 3; t++) begin
            step();
            chk("rst_no_rsp_after", 32'(a_rsp_valid), 32'h0);
        end
        a_req = 4'b0001;
        step();
        chk("rst_next_gnt", 32'(a_gnt), 32'b0001);
        step();
        step();
        chk("rst_next_rsp_valid", 32'(a_rsp_valid), 32'b0001);
        chk("rst_next_rsp_data", 32'(a_rsp_data), 32'h2F07);
        a_req = '0;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
